// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared instruction-set definitions for the fetch unit and its neighbours:
//   opcode constants, instruction field bit positions, register indices and
//   a helper that assembles a 28-bit instruction word from its fields.
//   Instruction layout: opcode[27:24] dst[23:16] src1[15:8] src0[7:0];
//   the STO literal occupies [15:0].
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    // Field bit positions inside the 28-bit instruction word
    localparam int OPC_MSB  = 27;
    localparam int OPC_LSB  = 24;
    localparam int DST_MSB  = 23;
    localparam int DST_LSB  = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC0_MSB = 7;
    localparam int SRC0_LSB = 0;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_BLE = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;
    localparam logic [3:0] OP_LED = 4'd6;

    // Register indices
    localparam logic [7:0] R0 = 8'd0;
    localparam logic [7:0] R1 = 8'd1;
    localparam logic [7:0] R2 = 8'd2;
    localparam logic [7:0] R3 = 8'd3;
    localparam logic [7:0] R4 = 8'd4;
    localparam logic [7:0] R5 = 8'd5;
    localparam logic [7:0] R6 = 8'd6;
    localparam logic [7:0] R7 = 8'd7;

    function automatic logic [27:0] make_instr(input logic [3:0] op,
                                               input logic [7:0] dst,
                                               input logic [7:0] src1,
                                               input logic [7:0] src0);
        return {op, dst, src1, src0};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Reader side of the combinational instruction ROM. Owns the program
//   counter, drives the ROM address, registers the returned word (one IR
//   stage) and slices it into decoded fields for the execute stage.
//   Handles stall, taken-branch redirect with a one-bubble flush, and 16-bit
//   PC wrap-around.
//
//   Optional feature macro: FETCH_JMP_SHORTCUT_EN
//     defined   : JMP is resolved here; PC jumps to the zero-extended dst
//                 field and the JMP slot is marked invalid (never issued).
//     undefined : JMP is issued like any other instruction and execute
//                 redirects through iBranchTaken.
//
// Ports
//   Clock          in   single clock, rising edge
//   Reset          in   synchronous, active-low
//   oInstrAddress  out  ROM address (equal to PC)
//   iInstruction   in   ROM data for oInstrAddress
//   iStall         in   execute not ready: hold PC and issued instruction
//   iBranchTaken   in   taken branch resolved in execute
//   iBranchTarget  in   redirect address, valid with iBranchTaken
//   oValid         out  decoded outputs carry a live instruction
//   oInstrPC       out  fetch address of the issued instruction
//   oOpcode        out  IR[27:24]
//   oDestination   out  IR[23:16]
//   oSourceAddr1   out  IR[15:8]
//   oSourceAddr0   out  IR[7:0]
//   oImmediate     out  IR[15:0]
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 28,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  oInstrAddress,
    input  logic [INSTR_WIDTH-1:0] iInstruction,
    input  logic                   iStall,
    input  logic                   iBranchTaken,
    input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
    output logic                   oValid,
    output logic [ADDR_WIDTH-1:0]  oInstrPC,
    output logic [3:0]             oOpcode,
    output logic [7:0]             oDestination,
    output logic [7:0]             oSourceAddr1,
    output logic [7:0]             oSourceAddr0,
    output logic [15:0]            oImmediate
);

    logic [ADDR_WIDTH-1:0]  r_pc_p0;
    logic [INSTR_WIDTH-1:0] r_ir_p1;
    logic [ADDR_WIDTH-1:0]  r_instr_pc_p1;
    logic                   r_vld_p1;

    logic [ADDR_WIDTH-1:0]  w_pc_inc;
    logic [ADDR_WIDTH-1:0]  w_pc_next;
    logic                   w_issue;

    // Natural-width add wraps 16'hFFFF to 16'h0000.
    assign w_pc_inc = r_pc_p0 + ADDR_WIDTH'(1);

`ifdef FETCH_JMP_SHORTCUT_EN
    logic w_is_jmp;

    // A JMP in the fetch slot redirects immediately and is not issued, so
    // it costs no bubble beyond its own slot.
    assign w_is_jmp  = (iInstruction[OPC_MSB:OPC_LSB] == OP_JMP);
    assign w_pc_next = w_is_jmp ? ADDR_WIDTH'(iInstruction[DST_MSB:DST_LSB]) : w_pc_inc;
    assign w_issue   = ~w_is_jmp;
`else
    assign w_pc_next = w_pc_inc;
    assign w_issue   = 1'b1;
`endif

    // Stage p0 -> p1: PC update and IR capture
    // Priority: reset, taken branch (even under stall), stall, normal fetch.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_pc_p0       <= RESET_PC;
            r_ir_p1       <= '0;
            r_instr_pc_p1 <= '0;
            r_vld_p1      <= 1'b0;
        end else if (iBranchTaken) begin
            r_pc_p0  <= iBranchTarget;
            r_ir_p1  <= '0;
            r_vld_p1 <= 1'b0;
        end else if (!iStall) begin
            r_ir_p1       <= iInstruction;
            r_instr_pc_p1 <= r_pc_p0;
            r_vld_p1      <= w_issue;
            r_pc_p0       <= w_pc_next;
        end
    end

    // Stage p1 outputs: pure slices of IR
    assign oInstrAddress = r_pc_p0;
    assign oValid        = r_vld_p1;
    assign oInstrPC      = r_instr_pc_p1;
    assign oOpcode       = r_ir_p1[OPC_MSB:OPC_LSB];
    assign oDestination  = r_ir_p1[DST_MSB:DST_LSB];
    assign oSourceAddr1  = r_ir_p1[SRC1_MSB:SRC1_LSB];
    assign oSourceAddr0  = r_ir_p1[SRC0_MSB:SRC0_LSB];
    assign oImmediate    = r_ir_p1[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed table of per-cycle vectors over a small program ROM, hand
//   sequences for JMP, wrap and priority corners, then randomized stimulus
//   over a random ROM checked against a cycle-level reference model.
//   Honours FETCH_JMP_SHORTCUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

`ifdef FETCH_JMP_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] oInstrAddress;
    logic [27:0] iInstruction;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [15:0] iBranchTarget = '0;
    logic        oValid;
    logic [15:0] oInstrPC;
    logic [3:0]  oOpcode;
    logic [7:0]  oDestination;
    logic [7:0]  oSourceAddr1;
    logic [7:0]  oSourceAddr0;
    logic [15:0] oImmediate;

    always #5 Clock = ~Clock;

    instruction_fetch_unit dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oInstrAddress(oInstrAddress),
        .iInstruction (iInstruction),
        .iStall       (iStall),
        .iBranchTaken (iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oValid       (oValid),
        .oInstrPC     (oInstrPC),
        .oOpcode      (oOpcode),
        .oDestination (oDestination),
        .oSourceAddr1 (oSourceAddr1),
        .oSourceAddr0 (oSourceAddr0),
        .oImmediate   (oImmediate)
    );

    // ---------------- ROM ----------------
    logic        rnd_mode = 1'b0;
    logic [27:0] rnd_rom [256];

    function automatic logic [27:0] prog_word(input logic [15:0] a);
        case (a)
            16'd1:   return make_instr(OP_STO, R7, 8'h00, 8'h01);
            16'd2:   return make_instr(OP_STO, R3, 8'h00, 8'h01);
            16'd3:   return make_instr(OP_STO, R4, 8'h03, 8'hE8);
            16'd4:   return make_instr(OP_STO, R5, 8'h00, 8'h00);
            16'd5:   return make_instr(OP_ADD, R5, R5, R3);
            16'd6:   return make_instr(OP_BLE, 8'd5, R5, R4);
            16'd8:   return make_instr(OP_ADD, R7, R7, R3);
            16'd9:   return make_instr(OP_JMP, 8'd2, 8'h00, 8'h00);
            default: return make_instr(OP_NOP, 8'h00, 8'h00, 8'h00);
        endcase
    endfunction

    always_comb begin
        iInstruction = '0;
        if (rnd_mode) iInstruction = rnd_rom[oInstrAddress[7:0]];
        else          iInstruction = prog_word(oInstrAddress);
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        st;
        logic        br;
        logic [15:0] tgt;
        int          chk;   // 0 none, 1 addr+valid, 2 +pc+opcode, 3 +immediate
        logic [15:0] eaddr;
        logic        evld;
        logic [15:0] eipc;
        logic [3:0]  eop;
        logic [15:0] eimm;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic br,
                                input logic [15:0] tgt, input int chk,
                                input logic [15:0] eaddr, input logic evld,
                                input logic [15:0] eipc, input logic [3:0] eop,
                                input logic [15:0] eimm);
        vec_t v;
        v.rst = rst; v.st = st; v.br = br; v.tgt = tgt; v.chk = chk;
        v.eaddr = eaddr; v.evld = evld; v.eipc = eipc; v.eop = eop; v.eimm = eimm;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic st, input logic br, input logic [15:0] tgt);
        Reset         = rst;
        iStall        = st;
        iBranchTaken  = br;
        iBranchTarget = tgt;
    endtask

    // Check the state visible now, then present the inputs for the next edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge Clock);
        if (v.chk >= 1) begin
            cmp({tag, "_addr"},  32'(oInstrAddress), 32'(v.eaddr));
            cmp({tag, "_valid"}, 32'(oValid),        32'(v.evld));
        end
        if (v.chk >= 2) begin
            cmp({tag, "_ipc"}, 32'(oInstrPC), 32'(v.eipc));
            cmp({tag, "_op"},  32'(oOpcode),  32'(v.eop));
        end
        if (v.chk >= 3) cmp({tag, "_imm"}, 32'(oImmediate), 32'(v.eimm));
        drive(v.rst, v.st, v.br, v.tgt);
    endtask

    // ---------------- reference model ----------------
    int          m_pc;
    int          m_ipc;
    bit          m_vld;
    int          m_word;

    function automatic int rom_model(input int a);
        return int'(rnd_rom[a % 256]);
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit br, input int tgt);
        int w;
        if (!rst) begin
            m_pc = 0; m_ipc = 0; m_vld = 0; m_word = 0;
        end else if (br) begin
            m_pc = tgt; m_vld = 0; m_word = 0;
        end else if (!st) begin
            w      = rom_model(m_pc);
            m_word = w;
            m_ipc  = m_pc;
            if (SHORTCUT && ((w / 16777216) % 16) == 5) begin
                m_pc  = (w / 65536) % 256;
                m_vld = 0;
            end else begin
                m_pc  = (m_pc + 1) % 65536;
                m_vld = 1;
            end
        end
    endtask

    vec_t tbl [18];

    initial begin
        // T1..T3: reset, stall, branch over the bench program
        tbl[0]  = mk(0,0,0,0, 0, 0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0, 1, 0,0,0,0,0);
        tbl[2]  = mk(0,0,0,0, 1, 0,0,0,0,0);
        tbl[3]  = mk(1,0,0,0, 1, 0,0,0,0,0);
        tbl[4]  = mk(1,0,0,0, 3, 1,1,0,OP_NOP,16'h0000);
        tbl[5]  = mk(1,0,0,0, 3, 2,1,1,OP_STO,16'h0001);
        tbl[6]  = mk(1,0,0,0, 3, 3,1,2,OP_STO,16'h0001);
        tbl[7]  = mk(1,1,0,0, 3, 4,1,3,OP_STO,16'd1000);
        tbl[8]  = mk(1,1,0,0, 3, 4,1,3,OP_STO,16'd1000);
        tbl[9]  = mk(1,0,0,0, 3, 4,1,3,OP_STO,16'd1000);
        tbl[10] = mk(1,0,0,0, 3, 5,1,4,OP_STO,16'h0000);
        tbl[11] = mk(1,0,0,0, 3, 6,1,5,OP_ADD,16'h0503);
        tbl[12] = mk(1,0,1,5, 3, 7,1,6,OP_BLE,16'h0504);
        tbl[13] = mk(1,0,0,0, 1, 5,0,0,0,0);
        tbl[14] = mk(1,0,0,0, 3, 6,1,5,OP_ADD,16'h0503);
        tbl[15] = mk(1,0,0,0, 3, 7,1,6,OP_BLE,16'h0504);
        tbl[16] = mk(1,0,0,0, 3, 8,1,7,OP_NOP,16'h0000);
        tbl[17] = mk(1,0,0,0, 3, 9,1,8,OP_ADD,16'h0703);

        for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("v%0d", i));

        // T4: JMP at address 9
`ifdef FETCH_JMP_SHORTCUT_EN
        step(mk(1,0,0,0,     1, 2,0,0,0,0),                 "jmp_slot");
        step(mk(1,0,0,0,     3, 3,1,2,OP_STO,16'h0001),     "jmp_t2");
        step(mk(1,0,1,'hFFFF,3, 4,1,3,OP_STO,16'd1000),     "jmp_t3");
`else
        step(mk(1,0,1,2,     3, 10,1,9,OP_JMP,16'h0000),    "jmp_issue");
        step(mk(1,0,0,0,     1, 2,0,0,0,0),                 "jmp_redir");
        step(mk(1,0,0,0,     3, 3,1,2,OP_STO,16'h0001),     "jmp_t2");
        step(mk(1,0,1,'hFFFF,3, 4,1,3,OP_STO,16'd1000),     "jmp_t3");
`endif
        // T5: wrap
        step(mk(1,0,0,0,     1, 16'hFFFF,0,0,0,0),          "wrap_tgt");
        step(mk(1,0,0,0,     3, 16'h0000,1,16'hFFFF,OP_NOP,0), "wrap_0");
        // T6: branch beats stall; stall holds at a JMP; branch beats JMP; reset beats branch
        step(mk(1,1,1,9,     3, 16'h0001,1,16'h0000,OP_NOP,0), "wrap_1");
        step(mk(1,1,0,0,     1, 9,0,0,0,0),                 "br_stall");
        step(mk(1,0,1,4,     1, 9,0,0,0,0),                 "stall_jmp");
        step(mk(1,0,0,0,     1, 4,0,0,0,0),                 "br_over_jmp");
        step(mk(0,0,1,16'h1234, 3, 5,1,4,OP_STO,16'h0000),  "pre_rst");
        step(mk(1,0,0,0,     1, 0,0,0,0,0),                 "rst_over_br");
        step(mk(1,0,0,0,     3, 1,1,0,OP_NOP,16'h0000),     "post_rst");

        // Randomized phase over a random ROM
        for (int i = 0; i < 256; i++) rnd_rom[i] = 28'($urandom);
        @(negedge Clock);
        rnd_mode = 1'b1;
        drive(0, 0, 0, 0);
        model_step(0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_st, r_br;
            logic [15:0] r_tgt;
            @(negedge Clock);
            cmp("rnd_addr",  32'(oInstrAddress), 32'(m_pc));
            cmp("rnd_valid", 32'(oValid),        32'(m_vld));
            if (m_vld) begin
                cmp("rnd_ipc",  32'(oInstrPC),     32'(m_ipc));
                cmp("rnd_op",   32'(oOpcode),      32'((m_word / 16777216) % 16));
                cmp("rnd_dst",  32'(oDestination), 32'((m_word / 65536) % 256));
                cmp("rnd_src1", 32'(oSourceAddr1), 32'((m_word / 256) % 256));
                cmp("rnd_src0", 32'(oSourceAddr0), 32'(m_word % 256));
                cmp("rnd_imm",  32'(oImmediate),   32'(m_word % 65536));
            end
            r_rst = ($urandom_range(0, 39) != 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_br  = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       r_tgt = 16'hFFFF;
                1:       r_tgt = 16'($urandom);
                default: r_tgt = 16'($urandom_range(0, 255));
            endcase
            drive(r_rst, r_st, r_br, r_tgt);
            model_step(r_rst, r_st, r_br, int'(r_tgt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
